// File: rtl/rom_loader_pkg.sv
// Shared definitions for the i4001 ROM bank program loader.
package rom_loader_pkg;

   localparam int unsigned ADDR_W    = 11;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned LEN_W     = 12;
   localparam int unsigned CS_W      = 4;
   localparam int unsigned ROM_WORDS = 2048;

   localparam logic [1:0] MODE_READ  = 2'b00;
   localparam logic [1:0] MODE_WRITE = 2'b01;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ACCEPT = 3'd1;
   localparam logic [2:0] ST_WRITE  = 3'd2;
   localparam logic [2:0] ST_VRD    = 3'd3;
   localparam logic [2:0] ST_VCMP   = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   // A burst can never cover more than the whole bank.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(ROM_WORDS)) ? LEN_W'(ROM_WORDS) : len;
   endfunction

endpackage

// File: rtl/rom_loader_addr_counter.sv
// Burst bookkeeping: wrapping ROM address counter plus remaining-word down-counter.
module rom_loader_addr_counter
   import rom_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_c_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;

   // Load on burst start, advance one word after each completed write.
   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         addr_d = base_i;
         cnt_d  = clamp_len(len_i);
      end else if (step_i) begin
         addr_d = addr_q + ADDR_W'(1);
         cnt_d  = cnt_q - LEN_W'(1);
      end
   end

   // Counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign addr_o   = addr_q;
   assign last_c_o = (cnt_q == LEN_W'(1));

endmodule

// File: rtl/rom_loader.sv
// Streams program words into the i4001 ROM bank, one write cycle per word.
// Optional read-back verify after each write: define ROM_LOADER_VERIFY_EN.
module rom_loader
   import rom_loader_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] rom_column_id,
   output logic [DATA_W-1:0] rom_in,
   output logic [1:0]        rom_mode,
   output logic [CS_W-1:0]   rom_read_id,
   input  logic [DATA_W-1:0] rom_out,
   output logic              busy,
   output logic              done,
   output logic              error
);

   logic [2:0]        state_q, state_d;
   logic              in_ready_q, busy_q, done_q;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] col_q, col_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              cnt_load, cnt_step, cnt_last;
   logic [ADDR_W-1:0] addr;
`ifdef ROM_LOADER_VERIFY_EN
   logic              error_q, error_d;
   logic [CS_W-1:0]   read_id_q, read_id_d;
`endif

   rom_loader_addr_counter u_cnt (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .load_i   (cnt_load),
      .step_i   (cnt_step),
      .base_i   (base_addr),
      .len_i    (length),
      .addr_o   (addr),
      .last_c_o (cnt_last)
   );

   // Next-state logic; the latched word lives in the rom_in register.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      din_d    = din_q;
      cnt_load = 1'b0;
      cnt_step = 1'b0;
`ifdef ROM_LOADER_VERIFY_EN
      error_d  = error_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_load = 1'b1;
`ifdef ROM_LOADER_VERIFY_EN
               error_d  = 1'b0;
`endif
               state_d  = (length == '0) ? ST_DONE : ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            if (in_valid && in_ready_q) begin
               din_d   = in_data;
               col_d   = addr;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
`ifdef ROM_LOADER_VERIFY_EN
            state_d  = ST_VRD;
`else
            cnt_step = 1'b1;
            state_d  = cnt_last ? ST_DONE : ST_ACCEPT;
`endif
         end
`ifdef ROM_LOADER_VERIFY_EN
         ST_VRD: begin
            state_d = ST_VCMP;
         end
         ST_VCMP: begin
            cnt_step = 1'b1;
            if (rom_out != din_q) error_d = 1'b1;
            state_d  = cnt_last ? ST_DONE : ST_ACCEPT;
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
`ifdef ROM_LOADER_VERIFY_EN
      read_id_d = (state_d == ST_VRD) ? col_d[ADDR_W-1 -: CS_W] : '0;
`endif
   end

   // State and registered outputs, decoded from the next state so they track the current state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         in_ready_q <= 1'b0;
         mode_q     <= MODE_READ;
         col_q      <= '0;
         din_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d == ST_ACCEPT);
         mode_q     <= (state_d == ST_WRITE) ? MODE_WRITE : MODE_READ;
         col_q      <= col_d;
         din_q      <= din_d;
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_DONE);
      end
   end

`ifdef ROM_LOADER_VERIFY_EN
   // Sticky verify flag and read-back chip select.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         error_q   <= 1'b0;
         read_id_q <= '0;
      end else begin
         error_q   <= error_d;
         read_id_q <= read_id_d;
      end
   end

   assign error       = error_q;
   assign rom_read_id = read_id_q;
`else
   logic unused_rom_out;
   assign unused_rom_out = ^rom_out;
   assign error          = 1'b0;
   assign rom_read_id    = '0;
`endif

   assign in_ready      = in_ready_q;
   assign rom_mode      = mode_q;
   assign rom_column_id = col_q;
   assign rom_in        = din_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader with a behavioural ROM bank and write scoreboard.
module tb_rom_loader;
   import rom_loader_pkg::*;

   logic              CLK = 1'b0;
   logic              RST_N, start, in_valid;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  length;
   logic [DATA_W-1:0] in_data, rom_out;
   logic              in_ready, busy, done, error;
   logic [ADDR_W-1:0] rom_column_id;
   logic [DATA_W-1:0] rom_in;
   logic [1:0]        rom_mode;
   logic [CS_W-1:0]   rom_read_id;

`ifdef ROM_LOADER_VERIFY_EN
   localparam int DONE_LAT = 4;
`else
   localparam int DONE_LAT = 2;
`endif

   typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
   typedef struct { logic [ADDR_W-1:0] base; logic [LEN_W-1:0] len; int exp_n; int gap; bit poke; } vec_t;

   wr_t  sb_q[$];
   vec_t vecs[7];
   int   n_vec = 0, n_miss = 0, writes_seen = 0;
   bit   prev_w = 1'b0, corrupt = 1'b0;
   logic [DATA_W-1:0] mem [0:ROM_WORDS-1];

   rom_loader dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .base_addr(base_addr), .length(length),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .rom_column_id(rom_column_id), .rom_in(rom_in), .rom_mode(rom_mode),
      .rom_read_id(rom_read_id), .rom_out(rom_out), .busy(busy), .done(done), .error(error)
   );

   always #5 CLK = ~CLK;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   // ROM bank model: synchronous write, registered read; optionally corrupts address 5.
   always @(posedge CLK) begin
      if (rom_mode == MODE_WRITE)
         mem[rom_column_id] <= (corrupt && rom_column_id == 11'd5) ? (rom_in ^ 16'h0001) : rom_in;
      rom_out <= mem[rom_column_id];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Write scoreboard: every write cycle must match the oldest accepted word.
   always @(negedge CLK) begin
      if (RST_N === 1'b1) begin
         if (rom_mode == MODE_WRITE) begin
            wr_t e;
            writes_seen++;
            check("back_to_back_write", 32'(prev_w), 0);
            if (sb_q.size() == 0) begin
               check("unexpected_write_addr", 32'(rom_column_id), 32'h7FFFFFFF);
            end else begin
               e = sb_q.pop_front();
               check("write_addr", 32'(rom_column_id), 32'(e.addr));
               check("write_data", 32'(rom_in), 32'(e.data));
               check("write_read_id", 32'(rom_read_id), 0);
            end
         end
         prev_w = (rom_mode == MODE_WRITE);
      end else begin
         prev_w = 1'b0;
      end
   end

   // Offer one word and wait (bounded) until the loader takes it.
   task automatic feed_word(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a, output bit ok);
      wr_t e;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge CLK);
         if (in_ready === 1'b1) begin
            ok     = 1'b1;
            e.addr = a;
            e.data = d;
            sb_q.push_back(e);
         end
         @(posedge CLK); #1;
      end
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic run_burst(input int v, input vec_t t, input bit exp_err);
      bit ok;
      writes_seen = 0;
      @(posedge CLK); #1;
      start = 1'b1; base_addr = t.base; length = t.len;
      in_valid = 1'b1; in_data = 16'hBAD0;
      @(posedge CLK); #1;
      start = 1'b0; base_addr = '0; length = '0;
      if (t.exp_n == 0) begin
         in_valid = 1'b0;
         @(negedge CLK);
         check("done_len0", 32'(done), 1);
         check("in_ready_len0", 32'(in_ready), 0);
         check("mode_len0", 32'(rom_mode), 32'(MODE_READ));
         @(negedge CLK);
         check("done_pulse_len0", 32'(done), 0);
         check("busy_len0", 32'(busy), 0);
      end else begin
         for (int w = 0; w < t.exp_n; w++) begin
            if (t.gap > 0 && w > 0) begin
               in_valid = 1'b0;
               repeat (t.gap) begin @(posedge CLK); #1; end
               if (t.poke && w == 1) begin
                  start = 1'b1; base_addr = 11'd999; length = 12'd7;
                  @(posedge CLK); #1;
                  start = 1'b0; base_addr = '0; length = '0;
               end
               @(negedge CLK);
               check("in_ready_held", 32'(in_ready), 1);
               check("busy_in_gap", 32'(busy), 1);
               @(posedge CLK); #1;
            end
            feed_word(16'hA001 + 16'(w) + 16'(v * 256), t.base + ADDR_W'(w), ok);
            if (!ok) return;
         end
         in_data = 16'hDEAD;
         for (int c = 1; c < DONE_LAT; c++) begin
            @(negedge CLK);
            check("done_early", 32'(done), 0);
         end
         @(negedge CLK);
         check("done", 32'(done), 1);
         check("busy_in_done", 32'(busy), 1);
         @(negedge CLK);
         check("done_pulse", 32'(done), 0);
         check("busy_end", 32'(busy), 0);
         repeat (3) begin
            @(negedge CLK);
            check("in_ready_after", 32'(in_ready), 0);
         end
         @(posedge CLK); #1;
         in_valid = 1'b0;
      end
      check("write_count", 32'(writes_seen), 32'(t.exp_n));
      check("sb_empty", 32'(sb_q.size()), 0);
      check("error", 32'(error), 32'(exp_err));
   endtask

   initial begin
      bit ok;
      RST_N = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      base_addr = '0; length = '0;
      vecs[0] = '{11'd0,    12'd4,    4,    0, 1'b0};
      vecs[1] = '{11'd2046, 12'd3,    3,    0, 1'b0};
      vecs[2] = '{11'd0,    12'd0,    0,    0, 1'b0};
      vecs[3] = '{11'd300,  12'd3,    3,    5, 1'b1};
      vecs[4] = '{11'd1000, 12'd1,    1,    0, 1'b0};
      vecs[5] = '{11'd5,    12'd4000, 2048, 0, 1'b0};
      vecs[6] = '{11'd2047, 12'd2,    2,    5, 1'b0};

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_mode", 32'(rom_mode), 32'(MODE_READ));
      check("rst_col", 32'(rom_column_id), 0);
      check("rst_rom_in", 32'(rom_in), 0);
      check("rst_read_id", 32'(rom_read_id), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_error", 32'(error), 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;

      for (int v = 0; v < 7; v++) run_burst(v, vecs[v], 1'b0);

      // Reset in the middle of a burst.
      writes_seen = 0;
      @(posedge CLK); #1;
      start = 1'b1; base_addr = 11'd50; length = 12'd10;
      @(posedge CLK); #1;
      start = 1'b0; base_addr = '0; length = '0;
      for (int w = 0; w < 3; w++) feed_word(16'h5000 + 16'(w), 11'd50 + ADDR_W'(w), ok);
      @(posedge CLK); #1;
      RST_N = 1'b0;
      @(negedge CLK);
      check("midrst_in_ready", 32'(in_ready), 0);
      check("midrst_mode", 32'(rom_mode), 32'(MODE_READ));
      check("midrst_col", 32'(rom_column_id), 0);
      check("midrst_rom_in", 32'(rom_in), 0);
      check("midrst_read_id", 32'(rom_read_id), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_error", 32'(error), 0);
      check("midrst_writes", 32'(writes_seen), 3);
      check("midrst_sb_empty", 32'(sb_q.size()), 0);
      in_valid = 1'b0;
      sb_q.delete();
      @(posedge CLK); #1;
      RST_N = 1'b1;
      run_burst(7, '{11'd60, 12'd2, 2, 0, 1'b0}, 1'b0);

`ifdef ROM_LOADER_VERIFY_EN
      // Corrupted read-back at address 5 flags error; the next start clears it.
      corrupt = 1'b1;
      run_burst(8, '{11'd3, 12'd4, 4, 0, 1'b0}, 1'b1);
      run_burst(9, '{11'd100, 12'd1, 1, 0, 1'b0}, 1'b0);
      corrupt = 1'b0;
`endif

      repeat (2) @(posedge CLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
